// File: rtl/muldiv_seq_pkg.sv
// rtl/muldiv_seq_pkg.sv - op codes, FSM states and iteration count for muldiv_seq
package muldiv_seq_pkg;
  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  localparam int         ITER_COUNT = 32;
  localparam logic [4:0] ITER_LAST  = 5'(ITER_COUNT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEG_A,
    ST_NEG_B,
    ST_ITER,
    ST_FIX_LO,
    ST_FIX_HI,
    ST_DONE
  } state_t;
endpackage

// File: rtl/muldiv_seq_adder.sv
// rtl/muldiv_seq_adder.sv - 32-bit adder with carry in/out, the unit's only arithmetic
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential MULT/MULTU/DIV/DIVU unit owning HI/LO, 37-cycle schedule
import muldiv_seq_pkg::*;

module muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state, state_next;
  logic [1:0]  op_r;
  logic        neg_a, neg_b, c_fix;
  logic [31:0] r, q, m;
  logic [4:0]  cnt;
  logic        accept, is_div, flip_q, fix_r;
  logic [31:0] add_a, add_b, add_s;
  logic        add_ci, add_co;

  // q holds a and m holds b for both op kinds; multiply is commutative so M/Q roles swap freely
  assign is_div = op_r[1];
  assign flip_q = neg_a ^ neg_b;
  assign fix_r  = is_div ? neg_a : flip_q;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        accept     = 1'b1;
        state_next = ST_NEG_A;
      end
      ST_NEG_A:  begin busy = 1'b1; state_next = ST_NEG_B; end
      ST_NEG_B:  begin busy = 1'b1; state_next = ST_ITER; end
      ST_ITER:   begin
        busy = 1'b1;
        if (cnt == ITER_LAST) state_next = ST_FIX_LO;
      end
      ST_FIX_LO: begin busy = 1'b1; state_next = ST_FIX_HI; end
      ST_FIX_HI: begin busy = 1'b1; state_next = ST_DONE; end
      ST_DONE:   begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = ST_NEG_A;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    add_a  = r;
    add_b  = 32'd0;
    add_ci = 1'b0;
    case (state)
      ST_NEG_A:  begin add_a = ~q; add_ci = 1'b1; end
      ST_NEG_B:  begin add_a = ~m; add_ci = 1'b1; end
      ST_ITER:   begin
        if (is_div) begin
          add_a  = {r[30:0], q[31]};
          add_b  = ~m;
          add_ci = 1'b1;
        end else begin
          add_a = r;
          add_b = q[0] ? m : 32'd0;
        end
      end
      ST_FIX_LO: begin add_a = ~q; add_ci = 1'b1; end
      ST_FIX_HI: begin add_a = ~r; add_ci = is_div ? 1'b1 : c_fix; end
      default:   ;
    endcase
  end

  adder_32bits u_adder (
    .a  (add_a),
    .b  (add_b),
    .ci (add_ci),
    .s  (add_s),
    .co (add_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      op_r  <= 2'b00;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      c_fix <= 1'b0;
      r     <= 32'd0;
      q     <= 32'd0;
      m     <= 32'd0;
      cnt   <= 5'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      if (accept) begin
        op_r  <= op;
        neg_a <= op[0] & a[31];
        neg_b <= op[0] & b[31];
        q     <= a;
        m     <= b;
        r     <= 32'd0;
        c_fix <= 1'b0;
      end else if (!busy) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
      case (state)
        ST_NEG_A: if (neg_a) q <= add_s;
        ST_NEG_B: begin
          if (neg_b) m <= add_s;
          cnt <= 5'd0;
        end
        ST_ITER: begin
          cnt <= cnt + 5'd1;
          if (!is_div) begin
            r <= {add_co, add_s[31:1]};
            q <= {add_s[0], q[31:1]};
          end else if (r[31] | add_co) begin
            r <= add_s;
            q <= {q[30:0], 1'b1};
          end else begin
            r <= {r[30:0], q[31]};
            q <= {q[30:0], 1'b0};
          end
        end
        ST_FIX_LO: begin
          if (flip_q) q <= add_s;
          if (!is_div) c_fix <= add_co;
        end
        ST_FIX_HI: begin
          if (fix_r) begin
            r  <= add_s;
            hi <= add_s;
          end else begin
            hi <= r;
          end
          lo <= q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq against an arithmetic reference
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0, b = 32'd0, wdata = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Returns {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [31:0] ua, ub, qq, rr;
    logic na, nb;
    if (o == OP_MULTU) return {32'd0, x} * {32'd0, y};
    if (o == OP_MULT) begin
      sx = $signed({{32{x[31]}}, x});
      sy = $signed({{32{y[31]}}, y});
      return sx * sy;
    end
    na = o[0] & x[31];
    nb = o[0] & y[31];
    ua = na ? -x : x;
    ub = nb ? -y : y;
    if (ub == 32'd0) begin
      qq = 32'hFFFF_FFFF;
      rr = ua;
    end else begin
      qq = ua / ub;
      rr = ua % ub;
    end
    if (na ^ nb) qq = -qq;
    if (na) rr = -rr;
    return {rr, qq};
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, output int n, output int busy_cycles);
    n = n0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 80) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [1:0]  t_op [7] = '{2'd0, 2'd1, 2'd1, 2'd3, 2'd2, 2'd2, 2'd3};
    logic [31:0] t_a  [7] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'd7, 32'h1234, 32'h80000000};
    logic [31:0] t_b  [7] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] t_hi [7] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'd1, 32'h1234, 32'd0};
    logic [31:0] t_lo [7] = '{32'h00000001, 32'hFFFFFFEB, 32'd0, 32'hFFFFFFFD, 32'd3, 32'hFFFFFFFF, 32'h80000000};
    int n, bc;
    for (int i = 0; i < 7; i++) begin
      launch(t_op[i], t_a[i], t_b[i]);
      wait_done(1, n, bc);
      n_checks++;
      if ({hi, lo} !== {t_hi[i], t_lo[i]}) begin
        n_fail++;
        $display("FAIL directed[%0d] result: hi=%h lo=%h, required hi=%h lo=%h", i, hi, lo, t_hi[i], t_lo[i]);
      end
      n_checks++;
      if (n !== 37 || bc !== 36) begin
        n_fail++;
        $display("FAIL directed[%0d] timing: done at %0d busy %0d cycles, required 37 and 36", i, n, bc);
      end
    end
  endtask

  task automatic test_mtlo_idle;
    logic [31:0] prev_hi;
    @(negedge clk);
    prev_hi = hi;
    wr_lo = 1'b1; wdata = 32'hA5A5A5A5;
    @(negedge clk);
    wr_lo = 1'b0;
    n_checks++;
    if ({hi, lo} !== {prev_hi, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("FAIL mtlo_idle: hi=%h lo=%h, required hi=%h lo=a5a5a5a5", hi, lo, prev_hi);
    end
  endtask

  task automatic test_busy_ignore;
    logic [63:0] prev;
    int n, bc;
    prev = {hi, lo};
    launch(OP_DIVU, 32'd100, 32'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd5;
    wr_hi = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    n_checks++;
    if ({hi, lo} !== prev) begin
      n_fail++;
      $display("FAIL busy_hold: hi/lo=%h, required %h", {hi, lo}, prev);
    end
    wait_done(6, n, bc);
    n_checks++;
    if (n !== 37 || {hi, lo} !== {32'd2, 32'd14}) begin
      n_fail++;
      $display("FAIL busy_ignore result: done at %0d hi=%h lo=%h, required 37 hi=2 lo=e", n, hi, lo);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ignore start: busy=%b after done, required 0", busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] x, y, lo1;
    logic [63:0] exp;
    int n, bc;
    x = $urandom; y = $urandom;
    launch(OP_MULTU, x, y);
    wait_done(1, n, bc);
    lo1 = lo;
    x = $urandom; y = $urandom_range(1, 1000);
    exp = ref_result(OP_DIV, x, y);
    wr_lo = 1'b1; wdata = 32'h11111111;
    launch(OP_DIV, x, y);
    wr_lo = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || lo !== lo1) begin
      n_fail++;
      $display("FAIL b2b accept: busy=%b lo=%h, required busy=1 lo=%h", busy, lo, lo1);
    end
    wait_done(1, n, bc);
    n_checks++;
    if (n !== 37 || {hi, lo} !== exp) begin
      n_fail++;
      $display("FAIL b2b second: done at %0d hi/lo=%h, required 37 %h", n, {hi, lo}, exp);
    end
  endtask

  task automatic test_random;
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp;
    int n, bc;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      case ($urandom_range(0, 5))
        0:       y = 32'd0;
        1:       y = $urandom_range(1, 9);
        2:       y = -($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      exp = ref_result(o, x, y);
      launch(o, x, y);
      wait_done(1, n, bc);
      n_checks++;
      if (n !== 37 || {hi, lo} !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: done at %0d hi/lo=%h, required 37 %h", i, o, x, y, n, {hi, lo}, exp);
      end
    end
  endtask

  task automatic test_rst_abort;
    logic saw;
    launch(OP_MULT, $urandom, $urandom);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, hi, lo} !== 66'd0) begin
      n_fail++;
      $display("FAIL rst_abort: busy=%b done=%b hi=%h lo=%h, required all zero", busy, done, hi, lo);
    end
    saw = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
    end
    n_checks++;
    if (saw !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort quiet: activity seen=%b, required 0", saw);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mtlo_idle();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_rst_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
